// File: rtl/tile_gfx_pkg.sv
// Shared definitions for the tile/sprite pixel engine: playfield window, motion-object register map,
// object record layout and the built-in sprite ROM test pattern.
package tile_gfx_pkg;

   localparam int WIN_COL0 = 200;
   localparam int WIN_ROW0 = 112;
   localparam int WIN_W    = 240;
   localparam int WIN_H    = 256;

   localparam logic [15:0] MOB_PIC_BASE  = 16'h13C0;
   localparam logic [15:0] MOB_ROW_BASE  = 16'h13D0;
   localparam logic [15:0] MOB_COL_BASE  = 16'h13E0;
   localparam logic [15:0] MOB_ATTR_BASE = 16'h13F0;
   localparam logic [9:0]  MOB_PAGE      = MOB_PIC_BASE[15:6];

   localparam int ATTR_EN    = 7;
   localparam int ATTR_WIDE  = 0;
   localparam int ATTR_VFLIP = 1;

   localparam int ROM_AW    = 14;
   localparam int ROM_WORDS = 1 << ROM_AW;

   typedef logic [1:0] pix_t;

   // Register field selected by addr[5:4] inside the motion-object page
   typedef enum logic [1:0] {
      FLD_PIC  = 2'd0,
      FLD_ROW  = 2'd1,
      FLD_COL  = 2'd2,
      FLD_ATTR = 2'd3
   } mob_field_e;

   typedef struct packed {
      logic [7:0] pic;
      logic [7:0] y;
      logic [7:0] x;
      logic [7:0] attr;
   } mob_t;

   // Test image used when no ROM file is given: XOR-fold of the 2-bit groups of the word address
   function automatic pix_t rom_pattern(input logic [ROM_AW-1:0] a);
      pix_t p;
      p = '0;
      for (int k = 0; k < ROM_AW / 2; k++) begin
         p = p ^ a[2*k +: 2];
      end
      return p;
   endfunction

endpackage

// File: rtl/mob_hit_unit.sv
// Hit test for one motion object against the current playfield position.
// Build option MOB_VFLIP_EN: ATTR bit1 mirrors the object vertically.
module mob_hit_unit
   import tile_gfx_pkg::*;
(
   input  mob_t       mob_i,
   input  logic [7:0] cent_col_i,
   input  logic [7:0] cent_row_i,
   input  logic       in_win_i,
   output logic       hit_o,
   output logic [2:0] mob_row_o,
   output logic [2:0] mob_col_o
);

   logic [8:0] dx_d;
   logic [8:0] dy_d;
   logic       wide_d;
   logic       x_ok_d;
   logic       y_ok_d;
   logic       unused_fields;

   // Bit 8 of each difference is set when the raster lies left of / above the object
   assign dx_d   = {1'b0, cent_col_i} - {1'b0, mob_i.x};
   assign dy_d   = {1'b0, cent_row_i} - {1'b0, mob_i.y};
   assign wide_d = mob_i.attr[ATTR_WIDE];

   assign x_ok_d = ~dx_d[8] && (wide_d ? (dx_d[7:4] == 4'd0) : (dx_d[7:3] == 5'd0));
   assign y_ok_d = ~dy_d[8] && (dy_d[7:3] == 5'd0);
   assign hit_o  = mob_i.attr[ATTR_EN] && in_win_i && x_ok_d && y_ok_d;

   // Wide objects stretch each source pixel across two screen columns
   assign mob_col_o = wide_d ? dx_d[3:1] : dx_d[2:0];

`ifdef MOB_VFLIP_EN
   assign mob_row_o     = mob_i.attr[ATTR_VFLIP] ? ~dy_d[2:0] : dy_d[2:0];
   assign unused_fields = ^{mob_i.pic, mob_i.attr[6:2]};
`else
   assign mob_row_o     = dy_d[2:0];
   assign unused_fields = ^{mob_i.pic, mob_i.attr[6:1]};
`endif

endmodule

// File: rtl/tile_sprite_pixel_engine.sv
// Pixel core: maps the VGA raster onto the 240x256 playfield, overlays 16 CPU-written motion objects
// and merges both 2-bit pixel codes. Build option MOB_VFLIP_EN enables per-object vertical flip.
module tile_sprite_pixel_engine
   import tile_gfx_pkg::*;
#(
   parameter string ROM_FILE = "sprites.hex",
   parameter int    NUM_MOB  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [8:0]  vga_row,
   input  logic [9:0]  vga_col,
   input  logic [15:0] addr,
   input  logic [7:0]  data_in,
   input  logic        we_l,
   input  logic [7:0]  static_id,
   output logic [9:0]  tile_addr,
   output logic [1:0]  color_code,
   output logic        pix_blank
);

   // ---------------- motion-object registers ----------------
   mob_t mob_q [NUM_MOB];
   logic mob_we;

   assign mob_we = ~we_l && (addr[15:6] == MOB_PAGE);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_MOB; i++) begin
            mob_q[i] <= '0;
         end
      end else if (mob_we) begin
         case (mob_field_e'(addr[5:4]))
            FLD_PIC:  mob_q[addr[3:0]].pic  <= data_in;
            FLD_ROW:  mob_q[addr[3:0]].y    <= data_in;
            FLD_COL:  mob_q[addr[3:0]].x    <= data_in;
            FLD_ATTR: mob_q[addr[3:0]].attr <= data_in;
            default:  ;
         endcase
      end
   end

   // ---------------- S0: window, tile address, hit tests ----------------
   logic       in_win;
   logic [7:0] cent_col;
   logic [7:0] cent_row;

   assign in_win = (vga_col >= 10'(WIN_COL0)) && (vga_col < 10'(WIN_COL0 + WIN_W)) &&
                   (vga_row >= 9'(WIN_ROW0))  && (vga_row < 9'(WIN_ROW0 + WIN_H));
   assign cent_col  = 8'(vga_col - 10'(WIN_COL0));
   assign cent_row  = 8'(vga_row - 9'(WIN_ROW0));
   assign tile_addr = in_win ? {cent_row[7:3], cent_col[7:3]} : 10'd0;

   logic [NUM_MOB-1:0] hit_w;
   logic [2:0]         mrow_w [NUM_MOB];
   logic [2:0]         mcol_w [NUM_MOB];

   generate
      for (genvar gi = 0; gi < NUM_MOB; gi++) begin : g_mob
         mob_hit_unit u_hit (
            .mob_i      (mob_q[gi]),
            .cent_col_i (cent_col),
            .cent_row_i (cent_row),
            .in_win_i   (in_win),
            .hit_o      (hit_w[gi]),
            .mob_row_o  (mrow_w[gi]),
            .mob_col_o  (mcol_w[gi])
         );
      end
   endgenerate

   logic       msel_d;
   logic [7:0] mid_d;
   logic [2:0] mrow_d;
   logic [2:0] mcol_d;

   // Scan from the top index down so the lowest hitting object is the one left standing
   always_comb begin
      msel_d = 1'b0;
      mid_d  = '0;
      mrow_d = '0;
      mcol_d = '0;
      for (int i = NUM_MOB - 1; i >= 0; i--) begin
         if (hit_w[i]) begin
            msel_d = 1'b1;
            mid_d  = mob_q[i].pic;
            mrow_d = mrow_w[i];
            mcol_d = mcol_w[i];
         end
      end
   end

   // ---------------- S1: registered position / object selection ----------------
   logic       blank_s1_q;
   logic [2:0] tile_row_s1_q;
   logic [2:0] tile_col_s1_q;
   logic       msel_s1_q;
   logic [7:0] mid_s1_q;
   logic [2:0] mrow_s1_q;
   logic [2:0] mcol_s1_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         blank_s1_q    <= 1'b1;
         tile_row_s1_q <= '0;
         tile_col_s1_q <= '0;
         msel_s1_q     <= 1'b0;
         mid_s1_q      <= '0;
         mrow_s1_q     <= '0;
         mcol_s1_q     <= '0;
      end else begin
         blank_s1_q    <= ~in_win;
         tile_row_s1_q <= cent_row[2:0];
         tile_col_s1_q <= cent_col[2:0];
         msel_s1_q     <= msel_d;
         mid_s1_q      <= mid_d;
         mrow_s1_q     <= mrow_d;
         mcol_s1_q     <= mcol_d;
      end
   end

   // ---------------- sprite ROM: one image, two registered read ports ----------------
   pix_t              rom_mem [ROM_WORDS];
   logic [ROM_AW-1:0] sta_addr;
   logic [ROM_AW-1:0] mot_addr;
   pix_t              sta_pix_q;
   pix_t              mot_pix_q;

   initial begin
      for (int i = 0; i < ROM_WORDS; i++) begin
         rom_mem[i] = rom_pattern(ROM_AW'(i));
      end
   end

   // static_id belongs to the pixel now held in S1 (playfield RAM has one cycle of read latency)
   assign sta_addr = {static_id, tile_row_s1_q, tile_col_s1_q};
   assign mot_addr = {mid_s1_q, mrow_s1_q, mcol_s1_q};

   always_ff @(posedge clk) begin
      sta_pix_q <= rom_mem[sta_addr];
      mot_pix_q <= rom_mem[mot_addr];
   end

   // ---------------- S2: merge ----------------
   logic blank_s2_q;
   logic msel_s2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         blank_s2_q <= 1'b1;
         msel_s2_q  <= 1'b0;
      end else begin
         blank_s2_q <= blank_s1_q;
         msel_s2_q  <= msel_s1_q;
      end
   end

   always_comb begin
      color_code = '0;
      if (!blank_s2_q) begin
         color_code = (msel_s2_q && (mot_pix_q != '0)) ? mot_pix_q : sta_pix_q;
      end
   end

   assign pix_blank = blank_s2_q;

endmodule

// File: tb/tb_tile_sprite_pixel_engine.sv
// Randomized bench for tile_sprite_pixel_engine against an integer-arithmetic model of the playfield,
// motion objects and built-in ROM image; honours MOB_VFLIP_EN like the design.
module tb_tile_sprite_pixel_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [8:0]  vga_row = '0;
   logic [9:0]  vga_col = '0;
   logic [15:0] addr = '0;
   logic [7:0]  data_in = '0;
   logic        we_l = 1'b1;
   logic [7:0]  static_id = '0;
   logic [9:0]  tile_addr;
   logic [1:0]  color_code;
   logic        pix_blank;

   always #5 clk = ~clk;

   tile_sprite_pixel_engine #(
      .ROM_FILE (""),
      .NUM_MOB  (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .vga_row    (vga_row),
      .vga_col    (vga_col),
      .addr       (addr),
      .data_in    (data_in),
      .we_l       (we_l),
      .static_id  (static_id),
      .tile_addr  (tile_addr),
      .color_code (color_code),
      .pix_blank  (pix_blank)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   // ---------------- reference model ----------------
   int pf_ram [1024];
   int m_pic [16];
   int m_y [16];
   int m_x [16];
   int m_attr [16];
   int prev_taddr = 0;

   typedef struct {
      int blank;
      int code;
      int c;
      int r;
   } exp_t;
   exp_t expq [$];

   // Test ROM image: word address {id,row,col}, value = XOR of its 2-bit groups
   function automatic int rom_ref(input int id, input int row, input int col);
      int a;
      int p;
      a = id * 64 + row * 8 + col;
      p = 0;
      for (int k = 0; k < 7; k++) p = p ^ ((a >> (2 * k)) & 3);
      return p;
   endfunction

   function automatic void model_clear();
      for (int n = 0; n < 16; n++) begin
         m_pic[n] = 0; m_y[n] = 0; m_x[n] = 0; m_attr[n] = 0;
      end
   endfunction

   function automatic void model_write(input int a, input int d);
      int n;
      n = a % 16;
      if (a >= 'h13C0 && a <= 'h13FF) begin
         case ((a - 'h13C0) / 16)
            0: m_pic[n] = d;
            1: m_y[n] = d;
            2: m_x[n] = d;
            default: m_attr[n] = d;
         endcase
      end
   endfunction

   function automatic void ref_pixel(input int c, input int r, output int blank, output int code,
                                     output int taddr);
      int cc, cr, dx, dy, wmax, mr, mc, mp;
      blank = 1; code = 0; taddr = 0;
      if (c < 200 || c >= 440 || r < 112 || r >= 368) return;
      cc = c - 200;
      cr = r - 112;
      blank = 0;
      taddr = (cr / 8) * 32 + cc / 8;
      code = rom_ref(pf_ram[taddr], cr % 8, cc % 8);
      for (int n = 0; n < 16; n++) begin
         dx = cc - m_x[n];
         dy = cr - m_y[n];
         wmax = (m_attr[n] & 1) ? 16 : 8;
         if ((m_attr[n] & 128) != 0 && dx >= 0 && dx < wmax && dy >= 0 && dy < 8) begin
            mr = dy;
`ifdef MOB_VFLIP_EN
            if ((m_attr[n] & 2) != 0) mr = 7 - dy;
`endif
            mc = (m_attr[n] & 1) ? dx / 2 : dx;
            mp = rom_ref(m_pic[n], mr, mc);
            if (mp != 0) code = mp;
            return;
         end
      end
   endfunction

   // ---------------- stimulus helpers ----------------
   // Called just after a rising edge: presents one pixel (and optional CPU write) for one clock
   task automatic cycle(input int c, input int r, input bit wr, input int a, input int d);
      int b, cd, ta;
      exp_t e;
      vga_col   = 10'(c);
      vga_row   = 9'(r);
      static_id = 8'(pf_ram[prev_taddr]);
      we_l      = ~wr;
      addr      = 16'(a);
      data_in   = 8'(d);
      ref_pixel(c, r, b, cd, ta);
      #1;
      check_eq($sformatf("tile_addr(%0d,%0d)", c, r), int'(tile_addr), ta);
      expq.push_back('{b, cd, c, r});
      prev_taddr = ta;
      if (wr) model_write(a, d);
      @(posedge clk);
      #1;
      if (expq.size() == 2) begin
         e = expq.pop_front();
         check_eq($sformatf("pix_blank(%0d,%0d)", e.c, e.r), int'(pix_blank), e.blank);
         check_eq($sformatf("color_code(%0d,%0d)", e.c, e.r), int'(color_code), e.code);
      end
   endtask

   task automatic wr_mob(input int a, input int d);
      cycle($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, a, d);
   endtask

   task automatic do_reset(input int c, input int r);
      rst     = 1'b1;
      we_l    = 1'b1;
      vga_col = 10'(c);
      vga_row = 9'(r);
      repeat (3) begin
         @(posedge clk);
         #1;
         check_eq("rst_blank", int'(pix_blank), 1);
         check_eq("rst_color", int'(color_code), 0);
      end
      model_clear();
      expq.delete();
      rst = 1'b0;
      cycle(c, r, 1'b0, 'h13C0, 0);
      check_eq("rst_hold_blank", int'(pix_blank), 1);
      check_eq("rst_hold_color", int'(color_code), 0);
   endtask

   function automatic int rand_mob_addr();
      return 'h13C0 + $urandom_range(0, 63);
   endfunction

   int other_addr [5] = '{'h13BF, 'h1400, 'h03C0, 'h93F0, 'h17E0};

   initial begin
      int c, r, n, a;
      bit wr;
      for (int i = 0; i < 1024; i++) pf_ram[i] = $urandom_range(0, 255);
      model_clear();

      do_reset(300, 200);

      // window corners and outside point
      cycle(100, 100, 1'b0, 'h13C0, 'h55);
      cycle(200, 112, 1'b0, 'h13C0, 'h55);
      cycle(439, 367, 1'b0, 'h13C0, 'h55);
      cycle(440, 368, 1'b0, 'h13C0, 'h55);

      // single sprite
      wr_mob('h13C0, 'h05); wr_mob('h13D0, 'h10); wr_mob('h13E0, 'h20); wr_mob('h13F0, 'h80);
      for (int i = 0; i < 9; i++) cycle(232 + i, 128 + i, 1'b0, 0, 0);

      // overlapping objects 0 and 1, then widened object 0 and vertical flip attribute
      wr_mob('h13C1, 'h37); wr_mob('h13D1, 'h10); wr_mob('h13E1, 'h20); wr_mob('h13F1, 'h80);
      for (int i = 0; i < 8; i++) cycle(232 + i, 128, 1'b0, 0, 0);
      wr_mob('h13F0, 'h81);
      for (int i = 13; i < 18; i++) cycle(232 + i, 129, 1'b0, 0, 0);
      wr_mob('h13F0, 'h82);
      for (int i = 0; i < 8; i++) cycle(232 + i, 128, 1'b0, 0, 0);
      cycle(232, 135, 1'b0, 0, 0);

      // randomized object sets with raster biased onto object footprints and interleaved writes
      repeat (6) begin
         for (int k = 0; k < 16; k++) begin
            wr_mob('h13C0 + k, $urandom_range(0, 255));
            wr_mob('h13D0 + k, $urandom_range(0, 255));
            wr_mob('h13E0 + k, $urandom_range(0, 250));
            wr_mob('h13F0 + k, ($urandom_range(0, 4) != 0 ? 'h80 : 0) | $urandom_range(0, 127));
         end
         repeat (150) begin
            n = $urandom_range(0, 15);
            c = 200 + m_x[n] + $urandom_range(0, 19) - 2;
            r = 112 + m_y[n] + $urandom_range(0, 11) - 2;
            if ($urandom_range(0, 9) == 0) begin
               c = $urandom_range(0, 639);
               r = $urandom_range(0, 479);
            end
            if (c > 639) c = 639;
            if (r > 479) r = 479;
            wr = ($urandom_range(0, 5) == 0);
            a = ($urandom_range(0, 7) == 0) ? other_addr[$urandom_range(0, 4)] : rand_mob_addr();
            cycle(c, r, wr, a, $urandom_range(0, 255));
         end
      end

      // reset mid-frame: in-flight pixels dropped, objects disabled afterwards
      cycle(240, 140, 1'b0, 0, 0);
      do_reset(240, 140);
      for (int i = 0; i < 10; i++) cycle(200 + i, 112 + i, 1'b0, 0, 0);

      cycle(0, 0, 1'b0, 0, 0);
      cycle(0, 0, 1'b0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
